// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front-end/back-end sequencer for a combinational mod_alu. Operand A,
//   operand B and the opcode are collected from the switches over three
//   button presses and driven as registered values into the ALU. The ALU
//   result and flags are captured one cycle later into display registers,
//   and executed operations are counted.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   sw              operand switches (WIDTH)
//   op_sw           opcode switches (4)
//   btn_next        advance/capture button, level
//   alu_a/alu_b     registered operands to mod_alu
//   alu_sel         registered opcode to mod_alu
//   alu_result, alu_cout, alu_negative, alu_zero   mod_alu outputs
//   result_q        captured result
//   flags_q         captured {cout, negative, zero}
//   state_q         FSM state code (LED display)
//   done            one-cycle pulse when result_q/flags_q update
//   op_err          sticky: last opcode press exceeded MAX_OP
//   op_count        executed-operation counter, wraps modulo 2^CNT_W
//
// Build option
//   BTN_SYNC_EN     when defined, btn_next goes through a 2-FF synchronizer
//                   ahead of the edge detector (press lags the pin by 3
//                   clocks instead of 1). FSM and datapath are unchanged.
module alu_op_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned MAX_OP = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [3:0]       op_sw,
  input  logic             btn_next,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] result_q,
  output logic [2:0]       flags_q,
  output logic [2:0]       state_q,
  output logic             done,
  output logic             op_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_e;

  localparam logic [3:0] MAX_OP_L = 4'(MAX_OP);

  state_e           st_q, st_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] result_r_q, result_r_d;
  logic [2:0]       flags_r_q, flags_r_d;
  logic             done_q, done_d;
  logic             op_err_q, op_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             btn_prev_q, btn_prev_d;
  logic             armed_q, armed_d;
  logic             btn_lvl;
  logic             press;

`ifdef BTN_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], btn_next};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign btn_lvl = sync_q[1];
`else
  assign btn_lvl = btn_next;
`endif

  // The edge history resets to 0, so a button held through reset release
  // would look like a rising edge. armed_q only sets once the button level
  // has been seen low, which suppresses that spurious press.
  assign press = btn_lvl & ~btn_prev_q & armed_q;

  always_comb begin
    st_d       = st_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    result_r_d = result_r_q;
    flags_r_d  = flags_r_q;
    done_d     = 1'b0;
    op_err_d   = op_err_q;
    op_count_d = op_count_q;
    btn_prev_d = btn_lvl;
    armed_d    = armed_q | ~btn_lvl;

    case (st_q)
      S_LOAD_A: begin
        if (press) begin
          alu_a_d = sw;
          st_d    = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (press) begin
          alu_b_d = sw;
          st_d    = S_LOAD_OP;
        end
      end
      S_LOAD_OP: begin
        if (press) begin
          if (op_sw > MAX_OP_L) begin
            op_err_d = 1'b1;
          end else begin
            alu_sel_d = op_sw;
            op_err_d  = 1'b0;
            st_d      = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_r_d = alu_result;
        flags_r_d  = {alu_cout, alu_negative, alu_zero};
        done_d     = 1'b1;
        op_count_d = op_count_q + CNT_W'(1);
        st_d       = S_SHOW;
      end
      S_SHOW: begin
        if (press) st_d = S_LOAD_A;
      end
      default: st_d = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_LOAD_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      result_r_q <= '0;
      flags_r_q  <= '0;
      done_q     <= 1'b0;
      op_err_q   <= 1'b0;
      op_count_q <= '0;
      btn_prev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      result_r_q <= result_r_d;
      flags_r_q  <= flags_r_d;
      done_q     <= done_d;
      op_err_q   <= op_err_d;
      op_count_q <= op_count_d;
      btn_prev_q <= btn_prev_d;
      armed_q    <= armed_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_sel  = alu_sel_q;
  assign result_q = result_r_q;
  assign flags_q  = flags_r_q;
  assign state_q  = st_q;
  assign done     = done_q;
  assign op_err   = op_err_q;
  assign op_count = op_count_q;

endmodule
